// File: rtl/axis_interp_pkg.sv
// Shared constants and types for the AXI4-Stream interpolator.
package axis_interp_pkg;

  // Largest log2 interpolation factor honoured by default.
  localparam int MAX_LOG_INTERP_DEF = 16;

  // Width of the log_interp control input.
  localparam int LOG_W = 5;

  // Interpolation mode encoding.
  localparam logic MODE_ZOH    = 1'b0;
  localparam logic MODE_LINEAR = 1'b1;

  // Segment sequencing: IDLE = no segment, EMIT = outputs k=0..N-1 in flight.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Clamp the requested log2 factor to the largest supported value.
  function automatic logic [LOG_W-1:0] sat_log(input logic [LOG_W-1:0] li,
                                               input int max_l);
    return (int'(li) > max_l) ? LOG_W'(max_l) : li;
  endfunction

endpackage

// File: rtl/axis_interp_lerp.sv
// Combinational sample generator: zero-order hold or linear interpolation
// between prev and cur at step k of a 2^l step segment.
module axis_interp_lerp
  import axis_interp_pkg::*;
#(
  parameter int W    = 32,
  parameter int MAXL = MAX_LOG_INTERP_DEF
) (
  input  logic [W-1:0]     prev,
  input  logic [W-1:0]     cur,
  input  logic [MAXL:0]    k,
  input  logic [LOG_W-1:0] l,
  input  logic             mode,
  output logic [W-1:0]     sample
);

  // Product width: W+1 bit delta times a step index below 2^MAXL.
  localparam int PW = W + 1 + MAXL;

  logic signed [W:0]    delta;
  logic signed [PW-1:0] delta_x;
  logic signed [PW-1:0] k_x;
  logic signed [PW-1:0] prod;

  // delta*k >>> l floors toward -inf; the sum stays between prev and cur,
  // so truncating back to W bits never overflows.
  always_comb begin
    delta   = $signed({cur[W-1], cur}) - $signed({prev[W-1], prev});
    delta_x = {{MAXL{delta[W]}}, delta};
    k_x     = {{W{1'b0}}, k};
    prod    = delta_x * k_x;
    if (mode == MODE_LINEAR) begin
      sample = prev + W'(prod >>> l);
    end else begin
      sample = cur;
    end
  end

endmodule

// File: rtl/axis_interpolator.sv
// AXI4-Stream upsampler: every accepted input yields 2^L outputs, either
// held (ZOH) or linearly interpolated from the previous input.
//
// Handshake: a beat moves on either side only in a cycle where both valid
// and ready are high at the rising edge of aclk; once M_AXIS_tvalid is
// raised, M_AXIS_tdata/M_AXIS_tvalid stay unchanged until M_AXIS_tready is
// seen high. S_AXIS_tready combinationally follows M_AXIS_tready on the
// last beat of a segment so the next segment starts with no gap.
module axis_interpolator
  import axis_interp_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LOG_INTERP   = MAX_LOG_INTERP_DEF
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [LOG_W-1:0]            log_interp,
  input  logic                        mode,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output state_t                      dbg_state
);

  localparam int W  = AXIS_TDATA_WIDTH;
  localparam int KW = MAX_LOG_INTERP + 1;

  state_t           state;
  state_t           state_next;
  logic [KW-1:0]    k;
  logic [KW-1:0]    last_k;
  logic [KW-1:0]    lp_k;
  logic [LOG_W-1:0] l_reg;
  logic [LOG_W-1:0] l_in;
  logic [LOG_W-1:0] lp_l;
  logic             mode_reg;
  logic             lp_mode;
  logic             primed;
  logic             ready_en;
  logic             m_valid;
  logic [W-1:0]     m_data;
  logic [W-1:0]     cur;
  logic [W-1:0]     prev;
  logic [W-1:0]     lp_prev;
  logic [W-1:0]     lp_cur;
  logic [W-1:0]     lp_sample;
  logic             accept;
  logic             xfer;
  logic             seg_end;
  logic             emit_on_accept;

  assign l_in    = sat_log(log_interp, MAX_LOG_INTERP);
  assign last_k  = (KW'(1) << l_reg) - KW'(1);
  assign seg_end = (state == EMIT) && (k == last_k);
  assign xfer    = m_valid && M_AXIS_tready;
  assign accept  = S_AXIS_tvalid && S_AXIS_tready;
  // The very first linear sample after reset only primes cur.
  assign emit_on_accept = (mode == MODE_ZOH) || primed;

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a new segment starts on accept, ends after beat N-1.
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = emit_on_accept ? EMIT : IDLE;
    end else if (xfer && seg_end) begin
      state_next = IDLE;
    end
  end

  // Output logic: take input when the output slot is free or freeing up
  // on the last beat of the current segment.
  always_comb begin
    S_AXIS_tready = ready_en && (!m_valid || (M_AXIS_tready && seg_end));
  end

  // Sample generator operands: on accept compute beat 0 of the new segment
  // from the incoming sample, otherwise the next beat of the current one.
  always_comb begin
    if (accept) begin
      lp_prev = cur;
      lp_cur  = S_AXIS_tdata;
      lp_k    = '0;
      lp_l    = l_in;
      lp_mode = mode;
    end else begin
      lp_prev = prev;
      lp_cur  = cur;
      lp_k    = k + KW'(1);
      lp_l    = l_reg;
      lp_mode = mode_reg;
    end
  end

  axis_interp_lerp #(
    .W    (W),
    .MAXL (MAX_LOG_INTERP)
  ) u_lerp (
    .prev   (lp_prev),
    .cur    (lp_cur),
    .k      (lp_k),
    .l      (lp_l),
    .mode   (lp_mode),
    .sample (lp_sample)
  );

  // Sample history, segment counter and registered output beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ready_en <= 1'b0;
      primed   <= 1'b0;
      prev     <= '0;
      cur      <= '0;
      l_reg    <= '0;
      mode_reg <= MODE_ZOH;
      k        <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        prev     <= cur;
        cur      <= S_AXIS_tdata;
        l_reg    <= l_in;
        mode_reg <= mode;
        primed   <= 1'b1;
        k        <= '0;
        m_valid  <= emit_on_accept;
        if (emit_on_accept) begin
          m_data <= lp_sample;
        end
      end else if (xfer) begin
        if (seg_end) begin
          m_valid <= 1'b0;
          k       <= '0;
        end else begin
          k      <= k + KW'(1);
          m_data <= lp_sample;
        end
      end
    end
  end

  assign M_AXIS_tdata  = m_data;
  assign M_AXIS_tvalid = m_valid;
  assign dbg_state     = state;

endmodule

// File: tb/tb_axis_interpolator.sv
// Bench for axis_interpolator: table of input rows with literal expected
// outputs, hand sequences for latency/gap, backpressure, saturation and
// mid-segment reset, plus random ZOH bursts under random backpressure.
module tb_axis_interpolator;
  import axis_interp_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic         aclk = 1'b0;
  logic         areset = 1'b0;
  logic [4:0]   log_interp = '0;
  logic         mode = 1'b0;
  logic [W-1:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_ready_man = 1'b1;
  logic         rnd_ready = 1'b1;
  logic         bp_rand = 1'b0;
  state_t       dbg_state;

  always #5 aclk = ~aclk;

  assign m_tready = bp_rand ? rnd_ready : m_ready_man;

  axis_interpolator #(
    .AXIS_TDATA_WIDTH (W),
    .MAX_LOG_INTERP   (16)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .log_interp    (log_interp),
    .mode          (mode),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tvalid (s_tvalid),
    .S_AXIS_tready (s_tready),
    .M_AXIS_tdata  (m_tdata),
    .M_AXIS_tvalid (m_tvalid),
    .M_AXIS_tready (m_tready),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           n_out = 0;
  int           last_xfer_cyc = 0;
  logic [W-1:0] exp_q[$];
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_d = '0;

  typedef struct packed {
    logic            rst;
    logic [W-1:0]    din;
    logic [4:0]      li;
    logic            md;
    logic [2:0]      n;
    logic [3:0][W-1:0] e;
  } vec_t;

  vec_t vecs[$];

  always @(posedge aclk) cyc++;

  always @(posedge aclk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, $signed(act), act, $signed(req), req, cyc);
    end
  endtask

  // Output monitor: pops the expected queue on every output transfer and
  // checks that a stalled beat is held unchanged.
  always @(negedge aclk) begin
    if (!areset) begin
      if (hold_v) begin
        check("hold_valid", W'(m_tvalid), W'(1));
        check("hold_data", m_tdata, hold_d);
      end
      hold_v = m_tvalid && !m_tready;
      hold_d = m_tdata;
      if (m_tvalid && m_tready) begin
        n_out++;
        last_xfer_cyc = cyc;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_extra: got unexpected output %0d, required none", $signed(m_tdata));
        end else begin
          check("sb_data", m_tdata, exp_q.pop_front());
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] d, input logic [4:0] li, input logic md);
    bit ok = 0;
    s_tdata    = d;
    log_interp = li;
    mode       = md;
    s_tvalid   = 1'b1;
    for (int i = 0; i < 100000 && !ok; i++) begin
      @(negedge aclk);
      if (s_tready) ok = 1;
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: input %0d not accepted, required acceptance", $signed(d));
    end
  endtask

  task automatic drain(input string name);
    int i = 0;
    while ((exp_q.size() != 0 || m_tvalid) && i < 100000) begin
      @(posedge aclk);
      #1;
      i++;
    end
    tests++;
    if (exp_q.size() != 0 || m_tvalid) begin
      fails++;
      $display("FAIL %s_drain: %0d outputs outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    areset   = 1'b1;
    exp_q.delete();
    #1;
    check("rst_tvalid", W'(m_tvalid), W'(0));
    check("rst_tdata", m_tdata, W'(0));
    check("rst_tready", W'(s_tready), W'(0));
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("rel_tready_before_edge", W'(s_tready), W'(0));
    @(posedge aclk);
    #1;
    check("rel_tready_after_edge", W'(s_tready), W'(1));
    check("rel_state", W'(dbg_state), W'(IDLE));
  endtask

  task automatic add_row(input logic rst, input logic [W-1:0] din, input logic [4:0] li,
                         input logic md, input int n, input logic [W-1:0] e0,
                         input logic [W-1:0] e1, input logic [W-1:0] e2,
                         input logic [W-1:0] e3);
    vec_t v;
    v.rst  = rst;
    v.din  = din;
    v.li   = li;
    v.md   = md;
    v.n    = 3'(n);
    v.e[0] = e0;
    v.e[1] = e1;
    v.e[2] = e2;
    v.e[3] = e3;
    vecs.push_back(v);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n0;
    int a0;
    vec_t v;
    logic [W-1:0] rd;
    int rl;

    #2;
    do_reset();

    // ZOH L=2, 5 then 9 back-to-back: latency 1 and no gap.
    n0 = n_out;
    for (int i = 0; i < 4; i++) exp_q.push_back(W'(5));
    send(W'(5), 5'd2, MODE_ZOH);
    a0 = cyc;
    check("lat1_valid", W'(m_tvalid), W'(1));
    check("lat1_data", m_tdata, W'(5));
    for (int i = 0; i < 4; i++) exp_q.push_back(W'(9));
    send(W'(9), 5'd2, MODE_ZOH);
    drain("zoh_b2b");
    check("zoh_b2b_count", W'(n_out - n0), W'(8));
    check("zoh_b2b_gapless", W'(last_xfer_cyc - a0), W'(7));

    // Table: {reset first, input, log_interp, mode, #outputs, expected}.
    add_row(1, W'(0),   2, MODE_LINEAR, 0, 0, 0, 0, 0);
    add_row(0, W'(8),   2, MODE_LINEAR, 4, 0, 2, 4, 6);
    add_row(0, -W'(8),  2, MODE_LINEAR, 4, 8, 4, 0, -W'(4));
    add_row(0, W'(0),   1, MODE_LINEAR, 2, -W'(8), -W'(4), 0, 0);
    add_row(1, W'(0),   1, MODE_LINEAR, 0, 0, 0, 0, 0);
    add_row(0, -W'(1),  1, MODE_LINEAR, 2, 0, -W'(1), 0, 0);
    add_row(0, -W'(1),  1, MODE_LINEAR, 2, -W'(1), -W'(1), 0, 0);
    add_row(0, W'(100), 1, MODE_ZOH,    2, 100, 100, 0, 0);
    add_row(0, W'(200), 2, MODE_LINEAR, 4, 100, 125, 150, 175);
    add_row(0, W'(42),  0, MODE_ZOH,    1, 42, 0, 0, 0);
    add_row(0, -W'(7),  0, MODE_ZOH,    1, -W'(7), 0, 0, 0);
    add_row(0, W'(3),   0, MODE_LINEAR, 1, -W'(7), 0, 0, 0);
    add_row(0, W'(4),   0, MODE_LINEAR, 1, 3, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) begin
        drain("table_pre_reset");
        do_reset();
      end
      for (int j = 0; j < int'(v.n); j++) exp_q.push_back(v.e[j]);
      send(v.din, v.li, v.md);
    end
    drain("table");

    // Random ZOH bursts under random backpressure.
    bp_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rd = W'($urandom);
      rl = $urandom_range(0, 2);
      for (int j = 0; j < (1 << rl); j++) exp_q.push_back(rd);
      send(rd, 5'(rl), MODE_ZOH);
      repeat ($urandom_range(0, 2)) @(posedge aclk);
      #1;
    end
    drain("random");
    bp_rand = 1'b0;
    @(posedge aclk);
    #1;

    // Backpressure: ZOH L=3, stall three cycles at k=2.
    n0 = n_out;
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(7));
    send(W'(7), 5'd3, MODE_ZOH);
    repeat (2) @(posedge aclk);
    #1;
    m_ready_man = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("bp_valid", W'(m_tvalid), W'(1));
      check("bp_data", m_tdata, W'(7));
      check("bp_s_tready", W'(s_tready), W'(0));
    end
    @(posedge aclk);
    #1;
    m_ready_man = 1'b1;
    drain("bp");
    check("bp_count", W'(n_out - n0), W'(8));

    // Saturation: log_interp=20 behaves as 16.
    n0 = n_out;
    for (int i = 0; i < 65536; i++) exp_q.push_back(W'(1));
    send(W'(1), 5'd20, MODE_ZOH);
    drain("sat");
    check("sat_count", W'(n_out - n0), W'(65536));
    check("sat_state_idle", W'(dbg_state), W'(IDLE));

    // Reset at k=3 of a linear N=8 segment, then re-priming.
    do_reset();
    send(W'(0), 5'd3, MODE_LINEAR);
    check("prime_no_output", W'(m_tvalid), W'(0));
    exp_q.push_back(W'(0));
    exp_q.push_back(W'(10));
    exp_q.push_back(W'(20));
    send(W'(80), 5'd3, MODE_LINEAR);
    repeat (3) @(posedge aclk);
    #2;
    check("mid_k3_data", m_tdata, W'(30));
    areset = 1'b1;
    #1;
    check("mid_rst_tvalid", W'(m_tvalid), W'(0));
    check("mid_rst_tready", W'(s_tready), W'(0));
    check("mid_rst_sb_empty", W'(exp_q.size()), W'(0));
    exp_q.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    n0 = n_out;
    send(W'(5), 5'd1, MODE_LINEAR);
    repeat (5) @(posedge aclk);
    #1;
    check("reprime_no_output", W'(n_out - n0), W'(0));
    check("reprime_tvalid", W'(m_tvalid), W'(0));
    exp_q.push_back(W'(5));
    exp_q.push_back(W'(9));
    send(W'(13), 5'd1, MODE_LINEAR);
    drain("reprime");
    check("reprime_count", W'(n_out - n0), W'(2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_interpolator.md
Name: axis_interpolator

Overview:
- AXI4-Stream upsampler; the inverse of the decimating throttler.
- Each accepted input sample produces 2^log_interp output samples, using either zero-order hold or linear interpolation between consecutive inputs.
- Sits between a low-rate sample source (e.g. PS-written waveform FIFO) and a full-rate consumer (e.g. DAC path) on aclk.

Parameters:
- AXIS_TDATA_WIDTH, 32, sample width; signed two's complement.
- MAX_LOG_INTERP, 16, largest honoured log_interp; larger inputs saturate to this value.

Ports:
- aclk  in  1  stream clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- log_interp  in  5  log2 of interpolation factor N; latched at segment start.
- mode  in  1  0 = zero-order hold, 1 = linear; latched at segment start.
- S_AXIS_tdata  in  AXIS_TDATA_WIDTH  input sample.
- S_AXIS_tvalid  in  1  input valid.
- S_AXIS_tready  out  1  input ready.
- M_AXIS_tdata  out  AXIS_TDATA_WIDTH  output sample, registered.
- M_AXIS_tvalid  out  1  output valid, registered.
- M_AXIS_tready  in  1  output ready.

Behaviour:
- Reset (async assert): M_AXIS_tvalid=0, M_AXIS_tdata=0, S_AXIS_tready=0 while areset=1.
- Reset also clears: counter k=0, prev=0, primed=0, state=IDLE.
- On deassert, S_AXIS_tready=1 from the first clock edge.
- L = min(log_interp, MAX_LOG_INTERP); N = 2^L. Counter k is MAX_LOG_INTERP+1 bits wide.
- States:
  - IDLE: no segment in progress.
  - EMIT: outputs k=0..N-1 of the current segment.
- Handshakes:
  - Input accepted when S_AXIS_tvalid && S_AXIS_tready.
  - Output transfer when M_AXIS_tvalid && M_AXIS_tready.
  - M_AXIS_tdata and M_AXIS_tvalid stay stable while tvalid=1 and tready=0.
- S_AXIS_tready = !M_AXIS_tvalid || (M_AXIS_tready && k==N-1 && state==EMIT). This is a combinational path from M_AXIS_tready, which is permitted. It gives gapless back-to-back segments.
- On accept: latch L and mode; cur <= S_AXIS_tdata; prev <= previous cur. The first output appears on M_AXIS the cycle after acceptance (latency 1).
- ZOH (mode=0): output value is cur for all k. Segment = N outputs, then next accept or IDLE.
- Linear (mode=1):
  - Output = prev + ((cur - prev) * k) >>> L.
  - delta is W+1 bits; product is W+1+MAX_LOG_INTERP bits; arithmetic shift floors toward -inf.
  - The result is truncated to W bits; it always lies in [min(prev,cur), max(prev,cur)], so no overflow.
- Linear priming: the first accepted sample after reset (primed=0) produces no output. It only loads cur and sets primed=1. Output is therefore one input period behind the input.
- Mode switch: prev/cur update on every accept in both modes, so switching ZOH->linear needs no re-priming. primed is cleared only by reset.
- L=0: N=1; ZOH acts as a registered pass-through, and linear outputs prev (one-sample delay).
- log_interp or mode changes mid-segment take effect at the next accept only.
- k wraps to 0 at the end of each segment. If no input is valid at the end, M_AXIS_tvalid=0 the next cycle and state=IDLE.
- Reset mid-segment: outputs drop immediately (async). Partial segment and primed state are discarded.

Decomposition:
- Package axis_interp_pkg:
  - MAX_LOG_INTERP default.
  - mode encoding constants MODE_ZOH=0, MODE_LINEAR=1.
  - state encoding IDLE/EMIT.
- Sub-module axis_interp_lerp: purely combinational datapath.
  - Inputs: prev, cur, k, L, mode.
  - Output: sample value (delta, multiply, shift, add).
- The top level keeps the counter, handshake, registers and state.

Test Plan:
- ZOH, log_interp=2, tready=1, inputs 5 then 9 back-to-back -> M_AXIS 5,5,5,5,9,9,9,9 on 8 consecutive cycles, no gap; first output 1 cycle after first accept.
- Linear, log_interp=2, inputs 0, 8, -8 -> no output for first sample, then 0,2,4,6,8,4,0,-4; afterwards tvalid=0.
- Linear floor rounding, log_interp=1, inputs 0, -1, -1 -> outputs 0,-1, then -1,-1.
- Backpressure: ZOH log_interp=3 input 7; drop M_AXIS_tready for 3 cycles at k=2 -> tdata=7 and tvalid held; S_AXIS_tready=0 throughout; 8 outputs total.
- log_interp=20 (saturation) with ZOH input 1 -> exactly 65536 outputs of 1; log_interp=0 -> each input appears once, 1-cycle latency.
- Assert areset at k=3 of a linear N=8 segment -> tvalid/tready=0 immediately. After release, the next input is priming-only (no output).
